// File: rtl/rotate_detect16.sv
// -----------------------------------------------------------------------------
// rotate_detect16
//
// Purpose:
//   Given an original 16-bit word (ref_in) and a rotated copy (rot_in), finds
//   the smallest left-rotate amount k (0..15) such that rotl(ref_in, k) equals
//   rot_in. The result is then expressed as the shortest rotation:
//   k <= 8 is reported as a left rotate by k, and k >= 9 as a right rotate by
//   16-k. The search is sequential and tests one candidate per clock.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous active-high reset
//   start   in   1   search request, only honoured in IDLE
//   ref_in  in  16   original (unrotated) word
//   rot_in  in  16   rotated word to decode
//   busy    out  1   high while searching
//   done    out  1   one-cycle pulse, result valid
//   found   out  1   1 = a rotation of ref_in equals rot_in
//   shift   out  4   decoded rotate amount, 0..8
//   lr      out  1   decoded direction, 1 = left, 0 = right
// -----------------------------------------------------------------------------
module rotate_detect16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ref_in,
    input  logic [15:0] rot_in,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [3:0]  shift,
    output logic        lr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [15:0] work_q,   work_d;     // ref_in rotated left by k_q
    logic [15:0] target_q, target_d;   // captured rot_in
    logic [3:0]  k_q,      k_d;        // candidate rotate amount under test
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        found_q,  found_d;
    logic [3:0]  shift_q,  shift_d;
    logic        lr_q,     lr_d;

    // Rotate a 16-bit word left by one position.
    function automatic logic [15:0] rotl1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    // Map a left-rotate amount k onto the shortest rotation: returns {lr, shift}.
    // k = 8 is ambiguous (left 8 == right 8) and is reported as left.
    function automatic logic [4:0] encode_rot(input logic [3:0] k);
        logic [4:0] diff;
        diff = 5'd16 - {1'b0, k};
        if (k <= 4'd8) begin
            return {1'b1, k};
        end else begin
            return {1'b0, diff[3:0]};
        end
    endfunction

    // Next-state and next-output computation for the search sequencer.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        target_d = target_q;
        k_d      = k_q;
        found_d  = found_q;
        shift_d  = shift_q;
        lr_d     = lr_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Operands are captured once; results from the previous
                    // search are cleared as the new one begins.
                    work_d   = ref_in;
                    target_d = rot_in;
                    k_d      = 4'd0;
                    found_d  = 1'b0;
                    shift_d  = 4'd0;
                    lr_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_SEARCH;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_SEARCH: begin
                if (work_q == target_q) begin
                    // First hit is the smallest k, so periodic words resolve
                    // to their shortest period.
                    found_d           = 1'b1;
                    {lr_d, shift_d}   = encode_rot(k_q);
                    done_d            = 1'b1;
                    state_d           = ST_DONE;
                end else if (k_q == 4'd15) begin
                    found_d  = 1'b0;
                    shift_d  = 4'd0;
                    lr_d     = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    work_d   = rotl1(work_q);
                    k_d      = k_q + 4'd1;
                    busy_d   = 1'b1;
                    state_d  = ST_SEARCH;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any search in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= 16'd0;
            target_q <= 16'd0;
            k_q      <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            shift_q  <= 4'd0;
            lr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            target_q <= target_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            shift_q  <= shift_d;
            lr_q     <= lr_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign shift = shift_q;
    assign lr    = lr_q;

endmodule

// File: tb/tb_rotate_detect16.sv
module tb_rotate_detect16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] ref_in;
    logic [15:0] rot_in;
    logic        busy;
    logic        done;
    logic        found;
    logic [3:0]  shift;
    logic        lr;

    int tests_run;
    int tests_failed;

    rotate_detect16 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ref_in (ref_in),
        .rot_in (rot_in),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .shift  (shift),
        .lr     (lr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a search, then wait for done and check latency and results.
    task automatic run_search(input string name, input logic [15:0] r, input logic [15:0] t,
                              input int exp_lat, input logic exp_found,
                              input logic [3:0] exp_shift, input logic exp_lr);
        int lat;
        int c;
        int bad_busy;
        lat = 0;
        c = 0;
        bad_busy = 0;
        @(negedge clk);
        ref_in = r;
        rot_in = t;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ref_in = 16'hFFFF;
        rot_in = 16'h5A5A;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy_after_start: busy=%b done=%b, required busy=1 done=0", name, busy, done);
        end
        tests_run++;
        if (found !== 1'b0 || shift !== 4'd0 || lr !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_cleared_on_start: found=%b shift=%0d lr=%b, required 0 0 0", name, found, shift, lr);
        end
        while (c < 40 && lat == 0) begin
            @(posedge clk);
            #1;
            c++;
            if (done === 1'b1) lat = c;
            else if (busy !== 1'b1) bad_busy++;
        end
        tests_run++;
        if (lat != exp_lat) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (bad_busy != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy_profile: gaps=%0d busy_at_done=%b, required 0 0", name, bad_busy, busy);
        end
        tests_run++;
        if (found !== exp_found || shift !== exp_shift || lr !== exp_lr) begin
            tests_failed++;
            $display("FAIL %s_result: found=%b shift=%0d lr=%b, required found=%b shift=%0d lr=%b",
                     name, found, shift, lr, exp_found, exp_shift, exp_lr);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || found !== exp_found || shift !== exp_shift || lr !== exp_lr) begin
            tests_failed++;
            $display("FAIL %s_hold: done=%b busy=%b found=%b shift=%0d lr=%b, required 0 0 %b %0d %b",
                     name, done, busy, found, shift, lr, exp_found, exp_shift, exp_lr);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start  = 1'b0;
        ref_in = 16'd0;
        rot_in = 16'd0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || shift !== 4'd0 || lr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b found=%b shift=%0d lr=%b, required all 0",
                     busy, done, found, shift, lr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_left_match;
        run_search("left_1234", 16'h1234, 16'h2341, 5, 1'b1, 4'd4, 1'b1);
    endtask

    task automatic test_right_match;
        run_search("right_1234", 16'h1234, 16'h4123, 13, 1'b1, 4'd4, 1'b0);
        run_search("right_k9", 16'h0001, 16'h0200, 10, 1'b1, 4'd7, 1'b0);
        run_search("right_k15", 16'h0001, 16'h8000, 16, 1'b1, 4'd1, 1'b0);
    endtask

    task automatic test_boundaries;
        run_search("bound_k8", 16'h00FF, 16'hFF00, 9, 1'b1, 4'd8, 1'b1);
        run_search("bound_periodic", 16'hAAAA, 16'hAAAA, 1, 1'b1, 4'd0, 1'b1);
        run_search("periodic_k1", 16'hAAAA, 16'h5555, 2, 1'b1, 4'd1, 1'b1);
    endtask

    task automatic test_no_match;
        run_search("no_match", 16'h0001, 16'h0003, 16, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_start_while_busy;
        int lat;
        int c;
        int extra_done;
        lat = 0;
        c = 0;
        extra_done = 0;
        @(negedge clk);
        ref_in = 16'h1234;
        rot_in = 16'h2341;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        c = 3;
        // k=3 now; present a competing request for one edge.
        ref_in = 16'h0001;
        rot_in = 16'h0002;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 4;
        if (done === 1'b1) lat = c;
        while (c < 40 && lat == 0) begin
            @(posedge clk);
            #1;
            c++;
            if (done === 1'b1) lat = c;
        end
        tests_run++;
        if (lat != 5) begin
            tests_failed++;
            $display("FAIL busy_start_latency: got %0d, required 5", lat);
        end
        tests_run++;
        if (found !== 1'b1 || shift !== 4'd4 || lr !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_result: found=%b shift=%0d lr=%b, required 1 4 1", found, shift, lr);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        tests_run++;
        if (extra_done != 0) begin
            tests_failed++;
            $display("FAIL busy_start_no_second: got %0d active cycles, required 0", extra_done);
        end
    endtask

    task automatic test_reset_mid_search;
        int spurious;
        spurious = 0;
        @(negedge clk);
        ref_in = 16'h0001;
        rot_in = 16'h0003;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || shift !== 4'd0 || lr !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b found=%b shift=%0d lr=%b, required all 0",
                     busy, done, found, shift, lr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_done: got %0d active cycles, required 0", spurious);
        end
        run_search("after_reset", 16'h8001, 16'h0003, 2, 1'b1, 4'd1, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_left_match();
        test_right_match();
        test_boundaries();
        test_no_match();
        test_start_while_busy();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
